// File: rtl/pulse_train_gen.sv
// pulse_train_gen: emits a burst of N clean rising edges on pulse_out.
// Each pulse is HIGH_CYC cycles high followed by LOW_CYC cycles low.
// `sent` counts edges as the downstream receiver sees them.
// Optional feature: define PULSE_GEN_ABORT_EN to add the `abort` port,
// which truncates a running burst without a done strobe.
module pulse_train_gen #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned HIGH_CYC = 1,
   parameter int unsigned LOW_CYC  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] n_pulses,
`ifdef PULSE_GEN_ABORT_EN
   input  logic             abort,
`endif
   output logic             pulse_out,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sent
);

   localparam int unsigned MAX_CYC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
   localparam int unsigned PW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
   localparam logic [PW-1:0] HIGH_LAST = PW'(HIGH_CYC - 1);
   localparam logic [PW-1:0] LOW_LAST  = PW'(LOW_CYC - 1);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

   state_t           state;
   logic [PW-1:0]    phase;
   logic [WIDTH-1:0] remaining;
   logic             abort_req;

`ifdef PULSE_GEN_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Burst FSM: phase timing, remaining-pulse count and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         phase     <= '0;
         remaining <= '0;
         pulse_out <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         sent      <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  phase <= '0;
                  if (n_pulses != '0) begin
                     // The first edge is counted in the cycle it appears.
                     state     <= HIGH;
                     pulse_out <= 1'b1;
                     busy      <= 1'b1;
                     sent      <= WIDTH'(1);
                     remaining <= n_pulses - WIDTH'(1);
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                     sent  <= '0;
                  end
               end
            end
            HIGH: begin
               if (abort_req) begin
                  state     <= IDLE;
                  phase     <= '0;
                  pulse_out <= 1'b0;
                  busy      <= 1'b0;
               end else if (phase == HIGH_LAST) begin
                  state     <= LOW;
                  phase     <= '0;
                  pulse_out <= 1'b0;
               end else begin
                  phase <= phase + PW'(1);
               end
            end
            LOW: begin
               if (abort_req) begin
                  state     <= IDLE;
                  phase     <= '0;
                  pulse_out <= 1'b0;
                  busy      <= 1'b0;
               end else if (phase == LOW_LAST) begin
                  phase <= '0;
                  if (remaining == '0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state     <= HIGH;
                     pulse_out <= 1'b1;
                     remaining <= remaining - WIDTH'(1);
                     sent      <= sent + WIDTH'(1);
                  end
               end else begin
                  phase <= phase + PW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Generates a programmable burst of clean rising edges on a single enable line. It is the transmitting end of the edge-counting enable interface: its `pulse_out` drives the `EN` input of the edge-detecting counters in the lab designs. Each started burst produces exactly N rising edges, so a downstream counter reset together with this block advances by exactly N. Pulse high and low widths are parameterised so the stimulus also exercises slow-edge detection.

## Interface
- `WIDTH`, default 8: width of the pulse count and of `sent`.
- `HIGH_CYC`, default 1: cycles `pulse_out` stays high per pulse; must be ≥ 1.
- `LOW_CYC`, default 1: cycles `pulse_out` stays low after each pulse; must be ≥ 1.
- `clk`  in  1: single clock; all logic on its posedge.
- `rst`  in  1: reset, synchronous, active-low.
- `start`  in  1: burst request; sampled only in IDLE.
- `n_pulses`  in  WIDTH: pulse count; latched when `start` is accepted.
- `abort`  in  1: stop the burst; present only with `PULSE_GEN_ABORT_EN`.
- `pulse_out`  out  1: registered enable line to the downstream counter.
- `busy`  out  1: high while in HIGH or LOW.
- `done`  out  1: one-cycle completion strobe.
- `sent`  out  WIDTH: rising edges emitted since the last accepted `start`.

## Operation
- FSM states: IDLE, HIGH, LOW, DONE.
- Reset:
  - `rst`=0 at a clock edge forces IDLE.
  - Clears `pulse_out`, `busy`, `done`, `sent`, the phase counter and the remaining count to 0.
  - Applies from any state, including mid-burst.
- IDLE:
  - `start`=1 with `n_pulses`≠0: latch N, clear `sent`, go to HIGH.
  - `start`=1 with `n_pulses`=0: clear `sent`, go to DONE; no pulse is emitted.
- HIGH:
  - `pulse_out`=1 for HIGH_CYC cycles, then go to LOW.
  - `sent` increments by 1 in the cycle `pulse_out` rises, counting edges as the receiver sees them.
- LOW:
  - `pulse_out`=0 for LOW_CYC cycles.
  - If `sent`==N, go to DONE; otherwise go to HIGH.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE, including during DONE, is ignored; there is no queueing.
- `sent` holds its final value until the next accepted `start` or a reset.
- Width rules:
  - The remaining count is WIDTH bits, so the maximum burst is 2^WIDTH−1 pulses.
  - The phase counter is sized to max(HIGH_CYC, LOW_CYC).
  - No wrap-around of `sent` is possible.

## Timing
- Let `start` be accepted at edge t. Then:
  - `pulse_out` is high in cycles t+1 … t+HIGH_CYC.
  - `pulse_out` is low in the following LOW_CYC cycles.
  - The period is P = HIGH_CYC + LOW_CYC.
  - Pulse k (k=1…N) rises in cycle t+1+(k−1)·P.
- `busy`=1 in cycles t+1 … t+N·P.
- `done`=1 in cycle t+N·P+1; `busy`=0 in that cycle.
- The earliest next `start` is accepted at edge t+N·P+2.
- For N=0, `done`=1 in cycle t+1.
- The last pulse is always followed by a full LOW phase, so the receiver sees the line low before `done`.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `PULSE_GEN_ABORT_EN`.
- Defined:
  - Adds the `abort` port.
  - `abort`=1 in HIGH or LOW: next cycle `pulse_out`=0, state goes to IDLE, `done` is not asserted.
  - `sent` holds the number of edges already emitted; a truncated high phase counts, matching the receiver.
  - When `abort` coincides with the final LOW cycle, `abort` wins and there is no `done`.
  - `abort` in IDLE or DONE is ignored.
- Undefined: no `abort` port; every accepted burst runs to completion.

## Test plan
All scenarios use HIGH_CYC=2, LOW_CYC=3, WIDTH=8.
- Reset, then `start`=1, `n_pulses`=3 → 3 rising edges 5 cycles apart, `busy` high for 15 cycles, `done` in cycle 16, `sent`=3; a reference edge counter reads 3.
- `start` with `n_pulses`=0 → `done` in the next cycle, `pulse_out` stays 0, `sent`=0, `busy` never high.
- `start` repulsed mid-burst with `n_pulses`=7 during a 4-pulse burst → exactly 4 pulses, `sent`=4; `start` held through the DONE cycle is ignored and accepted the cycle after.
- `rst`=0 after the 2nd pulse of a 10-pulse burst → all outputs 0 at the next edge; IDLE; no `done`.
- `n_pulses`=255 with HIGH_CYC=LOW_CYC=1 → 255 edges, `sent`=255, `done` at cycle 511.
- With `PULSE_GEN_ABORT_EN`, `abort` in the 2nd cycle of pulse 3 of 6 → `pulse_out` drops next cycle, `sent`=3, no `done`, state IDLE.
